branch_predict_unit: RTL and testbench

Parametrised branch resolution and prediction unit for the pipelined RV32I core. It resolves conditional branches in EX from ALU flags using RISC-V funct3 encoding and flags mispredictions for pipeline flush. It also holds a branch history table (BHT) of saturating counters that IF reads for next-PC prediction, plus saturating performance counters.

---
 rtl/branch_pkg.sv | 27 ++
 rtl/branch_predict_unit_sat_counter.sv | 28 ++
 rtl/branch_predict_unit.sv | 123 ++++++++++++
 tb/tb_branch_predict_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution / prediction unit:
// funct3 branch encodings, counter reset value and BHT index helper.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Widest PC the index helper accepts; callers zero-extend into this.
  localparam int PC_MAX_W = 64;

  // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  function automatic logic [31:0] ctr_reset(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Word-aligned PC bits [idx_w+1:2] select the BHT entry.
  function automatic logic [31:0] bht_idx(input logic [PC_MAX_W-1:0] pc, input int idx_w);
    logic [PC_MAX_W-1:0] sh;
    sh = pc >> 2;
    return sh[31:0] & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Combinational saturating up/down step: computes the next value of a
// counter without wrapping past zero or all-ones.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         en_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  // Clear wins, then a single-direction step that holds at the rails.
  always_comb begin
    cnt_o = cnt_i;
    if (clr_i) begin
      cnt_o = '0;
    end else if (en_i) begin
      if (inc_i && !dec_i && (cnt_i != '1)) begin
        cnt_o = cnt_i + W'(1);
      end else if (dec_i && !inc_i && (cnt_i != '0)) begin
        cnt_o = cnt_i - W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution in EX from ALU flags, misprediction flagging, a BHT of
// saturating counters read by IF, and saturating performance counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_pred_taken,
  input  logic             zf,
  input  logic             sf,
  input  logic             vf,
  input  logic             cf,
  output logic             ex_taken,
  output logic             ex_mispredict,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(ctr_reset(CTR_W));

  logic [CTR_W-1:0]    bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0]    br_q, br_d;
  logic [CNT_W-1:0]    mis_q, mis_d;
  logic [PC_MAX_W-1:0] if_pc_ext, ex_pc_ext;
  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic [CTR_W-1:0]    bht_upd;
  logic                cond, type_ok, legal;

  // Zero-extend both PCs and derive their BHT indices.
  always_comb begin
    if_pc_ext = '0;
    ex_pc_ext = '0;
    if_pc_ext[PC_W-1:0] = if_pc;
    ex_pc_ext[PC_W-1:0] = ex_pc;
    if_idx = IDX_W'(bht_idx(if_pc_ext, IDX_W));
    ex_idx = IDX_W'(bht_idx(ex_pc_ext, IDX_W));
  end

  // Branch condition from flags; funct3 010/011 are not branch types.
  always_comb begin
    cond    = 1'b0;
    type_ok = 1'b1;
    case (ex_funct3)
      F3_BEQ:  cond = zf;
      F3_BNE:  cond = ~zf;
      F3_BLT:  cond = sf ^ vf;
      F3_BGE:  cond = ~(sf ^ vf);
      F3_BLTU: cond = ~cf;
      F3_BGEU: cond = cf;
      default: type_ok = 1'b0;
    endcase
  end

  assign legal         = ex_valid & type_ok;
  assign ex_taken      = legal & cond;
  assign ex_mispredict = legal & (ex_taken ^ ex_pred_taken);
  assign ex_illegal    = ex_valid & ~type_ok;
  assign if_pred_taken = bht_q[if_idx][CTR_W-1];
  assign br_count      = br_q;
  assign mispred_count = mis_q;

  sat_counter #(.W(CTR_W)) u_bht_step (
    .cnt_i (bht_q[ex_idx]),
    .en_i  (legal),
    .inc_i (ex_taken),
    .dec_i (~ex_taken),
    .clr_i (1'b0),
    .cnt_o (bht_upd)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .cnt_i (br_q),
    .en_i  (legal),
    .inc_i (1'b1),
    .dec_i (1'b0),
    .clr_i (1'b0),
    .cnt_o (br_d)
  );

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .cnt_i (mis_q),
    .en_i  (ex_mispredict),
    .inc_i (1'b1),
    .dec_i (1'b0),
    .clr_i (1'b0),
    .cnt_o (mis_d)
  );

  // BHT array: whole-table clear on reset, one entry written per legal resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_RESET;
      end
    end else if (legal) begin
      bht_q[ex_idx] <= bht_upd;
    end
  end

  // Performance counters; reset drops any concurrent resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a behavioural reference model.
module tb_branch_predict_unit;

  localparam int ENTRIES = 64;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic [31:0]     ex_pc;
  logic [2:0]      ex_funct3;
  logic            ex_pred_taken;
  logic            zf, sf, vf, cf;
  logic            ex_taken, ex_mispredict, ex_illegal;
  logic [CNTW-1:0] br_count, mispred_count;

  int checks   = 0;
  int failures = 0;

  branch_predict_unit #(
    .BHT_ENTRIES(ENTRIES), .CTR_W(2), .PC_W(32), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
    .ex_pred_taken(ex_pred_taken), .zf(zf), .sf(sf), .vf(vf), .cf(cf),
    .ex_taken(ex_taken), .ex_mispredict(ex_mispredict), .ex_illegal(ex_illegal),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bht [ENTRIES];
  int m_br, m_mis;
  bit primed = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  // Branch rule in comparison terms: equal, signed-less, unsigned-less.
  function automatic void model_resolve(output bit leg, output bit tk);
    bit eq, slt, ult;
    eq  = zf;
    slt = (sf != vf);
    ult = !cf;
    leg = ex_valid && (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
    case (ex_funct3)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4: tk = slt;
      3'd5: tk = !slt;
      3'd6: tk = ult;
      3'd7: tk = !ult;
      default: tk = 0;
    endcase
    tk = tk && leg;
  endfunction

  // Check every cycle mid-period, then advance the model to the next edge.
  always @(negedge clk) begin
    bit leg, tk, mp, il;
    model_resolve(leg, tk);
    mp = leg && (tk != ex_pred_taken);
    il = ex_valid && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
    if (primed) begin
      chk("m_ex_taken", 32'(ex_taken), 32'(tk));
      chk("m_ex_mispredict", 32'(ex_mispredict), 32'(mp));
      chk("m_ex_illegal", 32'(ex_illegal), 32'(il));
      chk("m_if_pred_taken", 32'(if_pred_taken), 32'(m_bht[idx_of(if_pc)] >= 2));
      chk("m_br_count", 32'(br_count), 32'(m_br));
      chk("m_mispred_count", 32'(mispred_count), 32'(m_mis));
    end
    if (!rst_n) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_br   = 0;
      m_mis  = 0;
      primed = 1;
    end else if (leg) begin
      int e;
      e = idx_of(ex_pc);
      m_bht[e] = tk ? ((m_bht[e] < 3) ? m_bht[e] + 1 : 3)
                    : ((m_bht[e] > 0) ? m_bht[e] - 1 : 0);
      if (m_br < CNT_MAX) m_br++;
      if (mp && m_mis < CNT_MAX) m_mis++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [31:0] pc, input logic [2:0] f3,
                       input bit pr, input bit z, input bit s, input bit o, input bit c);
    ex_valid = v; ex_pc = pc; ex_funct3 = f3; ex_pred_taken = pr;
    zf = z; sf = s; vf = o; cf = c;
  endtask

  task automatic idle();
    drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0);
  endtask

  // Move to mid-cycle (after the model compare) for literal checks.
  task automatic mid();
    @(negedge clk); #1;
  endtask

  // Move to just after the next rising edge to drive new inputs.
  task automatic next();
    @(posedge clk); #1;
  endtask

  logic [CNTW-1:0] br_save, mis_save;

  initial begin
    rst_n = 0; if_pc = 32'h40; idle();
    next(); next();
    rst_n = 1;
    mid();
    chk("rst_pred_40", 32'(if_pred_taken), 32'd0);
    chk("rst_br", 32'(br_count), 32'd0);
    chk("rst_mis", 32'(mispred_count), 32'd0);
    next();

    // BEQ taken, predicted not-taken; IF reads same index this cycle.
    drive(1, 32'h40, 3'd0, 0, 1, 0, 0, 0);
    mid();
    chk("beq_taken", 32'(ex_taken), 32'd1);
    chk("beq_mispred", 32'(ex_mispredict), 32'd1);
    chk("same_cycle_old", 32'(if_pred_taken), 32'd0);
    next();
    idle();
    mid();
    chk("beq_pred_after", 32'(if_pred_taken), 32'd1);
    chk("beq_mis_cnt", 32'(mispred_count), 32'd1);
    chk("beq_br_cnt", 32'(br_count), 32'd1);
    next();

    // Signed / unsigned comparisons.
    drive(1, 32'h100, 3'd4, 0, 0, 1, 1, 0); mid(); chk("blt_eqsign", 32'(ex_taken), 32'd0); next();
    drive(1, 32'h104, 3'd5, 0, 0, 0, 1, 0); mid(); chk("bge_ovf",    32'(ex_taken), 32'd0); next();
    drive(1, 32'h108, 3'd6, 0, 0, 0, 0, 0); mid(); chk("bltu_nc",    32'(ex_taken), 32'd1); next();
    drive(1, 32'h10c, 3'd7, 0, 0, 0, 0, 0); mid(); chk("bgeu_nc",    32'(ex_taken), 32'd0); next();
    drive(1, 32'h110, 3'd1, 1, 0, 0, 0, 0); mid(); chk("bne_ok",     32'(ex_mispredict), 32'd0); next();

    // BHT saturation at 0x80.
    if_pc = 32'h80;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h80, 3'd0, 1, 1, 0, 0, 0);
      next();
    end
    idle();
    mid(); chk("sat_hi_pred", 32'(if_pred_taken), 32'd1); next();
    drive(1, 32'h80, 3'd1, 1, 1, 0, 0, 0);
    next();
    idle();
    mid(); chk("dec_one_pred", 32'(if_pred_taken), 32'd1); next();

    // Aliasing: 0x80 + 4*ENTRIES hits the same entry.
    if_pc = 32'h80 + 4 * ENTRIES;
    mid(); chk("alias_read", 32'(if_pred_taken), 32'd1); next();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h80 + 4 * ENTRIES, 3'd0, 1, 0, 0, 0, 0);
      next();
    end
    idle();
    if_pc = 32'h80;
    mid(); chk("alias_write", 32'(if_pred_taken), 32'd0); next();

    // Illegal funct3.
    br_save = br_count; mis_save = mispred_count;
    drive(1, 32'h40, 3'd2, 1, 1, 0, 0, 1);
    mid();
    chk("ill_flag", 32'(ex_illegal), 32'd1);
    chk("ill_taken", 32'(ex_taken), 32'd0);
    chk("ill_mispred", 32'(ex_mispredict), 32'd0);
    next();
    idle();
    mid();
    chk("ill_br_hold", 32'(br_count), 32'(br_save));
    chk("ill_mis_hold", 32'(mispred_count), 32'(mis_save));
    next();

    // Counter saturation.
    if_pc = 32'h200;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h200, 3'd0, 0, 1, 0, 0, 0);
      next();
    end
    idle();
    mid();
    chk("br_sat", 32'(br_count), 32'd15);
    chk("mis_sat", 32'(mispred_count), 32'd15);
    chk("pred_200", 32'(if_pred_taken), 32'd1);
    next();

    // Reset with a concurrent resolve.
    rst_n = 0;
    drive(1, 32'h200, 3'd0, 0, 1, 0, 0, 0);
    mid();
    chk("rst_comb_taken", 32'(ex_taken), 32'd1);
    chk("rst_pre_array", 32'(if_pred_taken), 32'd1);
    next();
    rst_n = 1;
    idle();
    mid();
    chk("rst2_pred_200", 32'(if_pred_taken), 32'd0);
    chk("rst2_br", 32'(br_count), 32'd0);
    chk("rst2_mis", 32'(mispred_count), 32'd0);
    next();
    if_pc = 32'h40;
    mid(); chk("rst2_pred_40", 32'(if_pred_taken), 32'd0); next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
